// File: rtl/start_fifo_srl_ctrl.sv
// Control plane for an SRL-based start-token FIFO: occupancy tracking, full/empty
// handshakes and the read index into an external shift-register storage array.
module start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    output logic [DATA_WIDTH-1:0] srl_din,
    input  logic [DATA_WIDTH-1:0] srl_dout
);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        EMPTY    = 2'd1,
        PARTIAL  = 2'd2,
        FULL     = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_U = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic [ADDR_WIDTH:0]   usedw_q;
    logic [ADDR_WIDTH:0]   usedw_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  push;
    logic                  pop;

    // Handshakes are gated by the registered flags, so overflow/underflow cannot occur.
    always_comb begin
        push    = if_write_ce & if_write & full_n_q;
        pop     = if_read_ce & if_read & empty_n_q;
        usedw_d = usedw_q;
        if (push && !pop) begin
            usedw_d = usedw_q + 1'b1;
        end else if (pop && !push) begin
            usedw_d = usedw_q - 1'b1;
        end
        // Newest entry sits at index 0, so the oldest is always at occupancy-1.
        addr_d = (usedw_d == '0) ? '0 : ADDR_WIDTH'(usedw_d - 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RST_HOLD;
            full_n_q  <= 1'b0;
            empty_n_q <= 1'b0;
            usedw_q   <= '0;
            addr_q    <= '0;
        end else begin
            usedw_q <= usedw_d;
            addr_q  <= addr_d;
            case (state_q)
                RST_HOLD: begin
                    state_q   <= EMPTY;
                    full_n_q  <= 1'b1;
                    empty_n_q <= 1'b0;
                end
                EMPTY: begin
                    if (push) begin
                        state_q   <= PARTIAL;
                        empty_n_q <= 1'b1;
                    end
                end
                PARTIAL: begin
                    if (usedw_d == DEPTH_U) begin
                        state_q  <= FULL;
                        full_n_q <= 1'b0;
                    end else if (usedw_d == '0) begin
                        state_q   <= EMPTY;
                        empty_n_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_q  <= PARTIAL;
                        full_n_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= RST_HOLD;
                    full_n_q  <= 1'b0;
                    empty_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign usedw      = usedw_q;
    assign srl_addr   = addr_q;
    assign srl_we     = push;
    assign srl_din    = if_din;
    assign if_dout    = srl_dout;

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Bench for start_fifo_srl_ctrl: directed and random traffic against a queue model,
// with a shift-register storage array attached as the parent would.
module tb_start_fifo_srl_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_write_ce, if_write, if_read_ce, if_read;
    logic [DW-1:0] if_din;
    logic          if_full_n, if_empty_n;
    logic [DW-1:0] if_dout;
    logic [AW:0]   usedw;
    logic          srl_we;
    logic [AW-1:0] srl_addr;
    logic [DW-1:0] srl_din, srl_dout;

    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // reference model: pending words oldest-first, plus the post-reset hold cycle
    logic [DW-1:0] q[$];
    bit            hold;

    always #5 clk = ~clk;

    start_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_write_ce(if_write_ce),
        .if_write   (if_write),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .if_read_ce (if_read_ce),
        .if_read    (if_read),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n),
        .usedw      (usedw),
        .srl_we     (srl_we),
        .srl_addr   (srl_addr),
        .srl_din    (srl_din),
        .srl_dout   (srl_dout)
    );

    // external SRL storage: shift in at index 0
    always @(posedge clk) begin
        if (srl_we) begin
            for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= srl_din;
        end
    end
    assign srl_dout = mem[srl_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        int n;
        n = q.size();
        chk({ctx, ":full_n"}, 32'(if_full_n), 32'(!hold && n < DEPTH));
        chk({ctx, ":empty_n"}, 32'(if_empty_n), 32'(!hold && n > 0));
        chk({ctx, ":usedw"}, 32'(usedw), 32'(n));
        chk({ctx, ":srl_addr"}, 32'(srl_addr), 32'((n > 0) ? n - 1 : 0));
        if (!hold && n > 0) chk({ctx, ":dout"}, 32'(if_dout), 32'(q[0]));
    endtask

    // Called at posedge+1; applies inputs for one cycle and checks the result after the edge.
    task automatic step(input string ctx, input logic wce, input logic wr,
                        input logic rce, input logic rd, input logic [DW-1:0] d);
        bit exp_push, exp_pop;
        if_write_ce = wce;
        if_write    = wr;
        if_read_ce  = rce;
        if_read     = rd;
        if_din      = d;
        #1;
        exp_push = wce && wr && !hold && (q.size() < DEPTH);
        exp_pop  = rce && rd && !hold && (q.size() > 0);
        chk({ctx, ":srl_we"}, 32'(srl_we), 32'(exp_push));
        chk({ctx, ":srl_din"}, 32'(srl_din), 32'(d));
        @(posedge clk);
        if (hold) hold = 1'b0;
        else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_push) q.push_back(d);
        end
        #1;
        check_outputs(ctx);
    endtask

    logic [DW-1:0] pat [4];

    initial begin
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
        reset_n = 1'b0;
        if_write_ce = 1'b1; if_write = 1'b1; if_din = 8'h55;
        if_read_ce = 1'b1;  if_read = 1'b1;
        hold = 1'b1;
        q.delete();

        // reset: flags low and write strobe gated even with requests asserted
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset:srl_we", 32'(srl_we), 32'd0);
        reset_n = 1'b1;
        #1;
        check_outputs("release");
        step("hold_exit", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // fill to full, then a write while full must not strobe storage
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b1, 1'b0, 1'b0, pat[i]);
        step("wr_full", 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        step("rd_empty", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // push into empty with read asserted, then clock-enable-low cycles
        step("push_empty_rd", 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);
        step("wce0", 1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
        step("rce0", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        step("push2", 1'b1, 1'b1, 1'b0, 1'b0, 8'h4D);

        // simultaneous push/pop at occupancy 2
        for (int i = 0; i < 5; i++) step("pushpop", 1'b1, 1'b1, 1'b1, 1'b1, 8'(8'h60 + i));
        for (int i = 0; i < 2; i++) step("pp_drain", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0),
                 8'($urandom));
        end

        // asynchronous reset mid-stream at occupancy 3
        while (q.size() > 0) step("pre_rst", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step("pre_fill", 1'b1, 1'b1, 1'b0, 1'b0, pat[i]);
        chk("pre_rst:usedw", 32'(usedw), 32'd3);
        if_write_ce = 1'b0; if_read_ce = 1'b0;
        #2;
        reset_n = 1'b0;
        hold = 1'b1;
        q.delete();
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("in_rst");
        reset_n = 1'b1;
        step("rst_exit", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step("fresh_push", 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        step("fresh_pop", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
